// File: rtl/cve2_mac_iter_if.sv
// Request/response bundle for the iterative MAC unit.
// The slave side is the MAC itself and the master side is the issuing stage.
interface cve2_mac_iter_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] op_a_i;
  logic [WIDTH-1:0] op_b_i;
  logic [WIDTH-1:0] acc_i;
  logic             signed_i;
  logic             sub_i;
  logic             sat_i;
  logic             flush_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] result_o;
  logic             overflow_o;

  modport slave (
    input  valid_i, op_a_i, op_b_i, acc_i, signed_i, sub_i, sat_i, flush_i, ready_i,
    output ready_o, valid_o, result_o, overflow_o
  );

  modport master (
    output valid_i, op_a_i, op_b_i, acc_i, signed_i, sub_i, sat_i, flush_i, ready_i,
    input  ready_o, valid_o, result_o, overflow_o
  );
endinterface

// File: rtl/cve2_mac_iter.sv
// Multi-cycle multiply-accumulate: shift-add on operand magnitudes, then one exact
// accumulate step with wrap or saturation and overflow detection.
module cve2_mac_iter #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 2
) (
  input logic            clk_i,
  input logic            rst_i,
  cve2_mac_iter_if.slave bus
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N) + 1;
  localparam int PW = 2 * WIDTH;
  localparam int SW = 2 * WIDTH + 2;

  typedef enum logic [1:0] {IDLE, MULT, ACC, DONE} state_t;

  state_t state_q, state_d;

  logic [PW-1:0]    mcand_q;
  logic [PW-1:0]    prod_q;
  logic [PW-1:0]    partial;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] result_q;
  logic             ovf_q;
  logic             neg_q;
  logic             sgn_q;
  logic             sub_q;
  logic             sat_q;
  logic [CW-1:0]    cnt_q;

  logic             accept;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  logic signed [SW-1:0] prod_s;
  logic signed [SW-1:0] acc_x;
  logic signed [SW-1:0] sum_s;
  logic signed [SW-1:0] max_s;
  logic signed [SW-1:0] min_s;
  logic [WIDTH-1:0]     acc_res;
  logic                 acc_ovf;

  assign accept       = (state_q == IDLE) && bus.valid_i && !bus.flush_i;
  assign bus.ready_o  = (state_q == IDLE) && !bus.flush_i && !rst_i;
  assign bus.valid_o  = (state_q == DONE);
  assign bus.result_o = result_q;
  assign bus.overflow_o = ovf_q;

  assign abs_a = (bus.signed_i && bus.op_a_i[WIDTH-1]) ? -bus.op_a_i : bus.op_a_i;
  assign abs_b = (bus.signed_i && bus.op_b_i[WIDTH-1]) ? -bus.op_b_i : bus.op_b_i;

  // Flush overrides every transition, including accept and the result handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = MULT;
      MULT:    if (cnt_q == CW'(N - 1)) state_d = ACC;
      ACC:     state_d = DONE;
      DONE:    if (bus.ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.flush_i) state_d = IDLE;
  end

  always_comb begin
    partial = '0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (mplier_q[j]) partial = partial + (mcand_q << j);
    end
  end

  // Two guard bits keep acc +/- product exact for every operand combination.
  always_comb begin
    prod_s = {2'b00, prod_q};
    if (neg_q) prod_s = -prod_s;
    acc_x = sgn_q ? {{(SW-WIDTH){acc_q[WIDTH-1]}}, acc_q} : {{(SW-WIDTH){1'b0}}, acc_q};
    sum_s = sub_q ? (acc_x - prod_s) : (acc_x + prod_s);

    max_s = '0;
    min_s = '0;
    if (sgn_q) begin
      max_s[WIDTH-2:0] = '1;
      min_s            = '1;
      min_s[WIDTH-2:0] = '0;
    end else begin
      max_s[WIDTH-1:0] = '1;
    end

    acc_ovf = (sum_s > max_s) || (sum_s < min_s);
    acc_res = sum_s[WIDTH-1:0];
    if (sat_q && (sum_s > max_s)) acc_res = max_s[WIDTH-1:0];
    else if (sat_q && (sum_s < min_s)) acc_res = min_s[WIDTH-1:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      neg_q    <= 1'b0;
      sgn_q    <= 1'b0;
      sub_q    <= 1'b0;
      sat_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mcand_q  <= {{WIDTH{1'b0}}, abs_a};
        mplier_q <= abs_b;
        prod_q   <= '0;
        acc_q    <= bus.acc_i;
        sgn_q    <= bus.signed_i;
        sub_q    <= bus.sub_i;
        sat_q    <= bus.sat_i;
        neg_q    <= bus.signed_i && (bus.op_a_i[WIDTH-1] ^ bus.op_b_i[WIDTH-1]);
        cnt_q    <= '0;
      end
      if (state_q == MULT) begin
        prod_q   <= prod_q + partial;
        mcand_q  <= mcand_q << BITS_PER_CYCLE;
        mplier_q <= mplier_q >> BITS_PER_CYCLE;
        cnt_q    <= cnt_q + CW'(1);
      end
      // A flush during the accumulate step must leave the previous result visible.
      if ((state_q == ACC) && !bus.flush_i) begin
        result_q <= acc_res;
        ovf_q    <= acc_ovf;
      end
    end
  end

endmodule

// File: tb/tb_cve2_mac_iter.sv
// Directed and randomized bench for cve2_mac_iter, using an arithmetic reference model
// and covering 32-bit/2-bit-per-cycle plus 16-bit/4-bit-per-cycle instances.
module tb_cve2_mac_iter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  cve2_mac_iter_if #(.WIDTH(32)) bus ();
  cve2_mac_iter_if #(.WIDTH(16)) bus16 ();

  cve2_mac_iter #(.WIDTH(32), .BITS_PER_CYCLE(2)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  cve2_mac_iter #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut16 (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus16)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic signed [127:0] to_int(input logic [31:0] v, input int w, input bit sgn);
    logic signed [127:0] r;
    r = 0;
    for (int i = 0; i < w; i++) r[i] = v[i];
    if (sgn && v[w-1]) r = r - (128'sd1 <<< w);
    return r;
  endfunction

  // Mathematical MAC: exact integer result, then range check, clamp or modulo 2^w.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [31:0] acc,
                                input bit sgn, input bit sub, input bit sat, input int w,
                                output logic [31:0] res, output logic ovf);
    logic signed [127:0] s, maxv, minv, r;
    if (sub) s = to_int(acc, w, sgn) - to_int(a, w, sgn) * to_int(b, w, sgn);
    else     s = to_int(acc, w, sgn) + to_int(a, w, sgn) * to_int(b, w, sgn);
    maxv = sgn ? (128'sd1 <<< (w - 1)) - 128'sd1 : (128'sd1 <<< w) - 128'sd1;
    minv = sgn ? -(128'sd1 <<< (w - 1)) : 128'sd0;
    ovf  = (s > maxv) || (s < minv);
    r = s;
    if (sat && (s > maxv)) r = maxv;
    else if (sat && (s < minv)) r = minv;
    res = '0;
    for (int i = 0; i < w; i++) res[i] = r[i];
  endfunction

  task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b, input logic [31:0] acc,
                                input bit sgn, input bit sub, input bit sat,
                                input logic [31:0] exp_res, input logic exp_ovf,
                                input int stall, input string tag);
    int n;
    int lat;
    n = 0;
    @(negedge clk);
    while (!bus.ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_output({tag, "/ready"}, bus.ready_o, 1);
    bus.valid_i  = 1'b1;
    bus.op_a_i   = a;
    bus.op_b_i   = b;
    bus.acc_i    = acc;
    bus.signed_i = sgn;
    bus.sub_i    = sub;
    bus.sat_i    = sat;
    @(posedge clk);
    #1;
    bus.valid_i  = 1'b0;
    bus.op_a_i   = $urandom;
    bus.op_b_i   = $urandom;
    bus.acc_i    = $urandom;
    bus.signed_i = ~sgn;
    bus.sub_i    = ~sub;
    bus.sat_i    = ~sat;
    lat = 0;
    while (!bus.valid_o && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_output({tag, "/latency"}, lat, 17);
    check_output({tag, "/result"}, bus.result_o, exp_res);
    check_output({tag, "/overflow"}, bus.overflow_o, exp_ovf);
    bus.ready_i = (stall == 0);
    for (int i = 0; i < stall; i++) begin
      bus.valid_i = 1'b1;
      @(posedge clk);
      #1;
      check_output({tag, "/hold_valid"}, bus.valid_o, 1);
      check_output({tag, "/hold_result"}, {bus.overflow_o, bus.result_o}, {exp_ovf, exp_res});
      check_output({tag, "/hold_ready"}, bus.ready_o, 0);
    end
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    @(posedge clk);
    #1;
    check_output({tag, "/post_valid"}, bus.valid_o, 0);
    check_output({tag, "/post_ready"}, bus.ready_o, 1);
  endtask

  task automatic apply16(input logic [15:0] a, input logic [15:0] b, input logic [15:0] acc,
                         input bit sat, input logic [15:0] exp_res, input logic exp_ovf,
                         input string tag);
    int lat;
    @(negedge clk);
    check_output({tag, "/ready"}, bus16.ready_o, 1);
    bus16.valid_i  = 1'b1;
    bus16.op_a_i   = a;
    bus16.op_b_i   = b;
    bus16.acc_i    = acc;
    bus16.signed_i = 1'b0;
    bus16.sub_i    = 1'b0;
    bus16.sat_i    = sat;
    @(posedge clk);
    #1;
    bus16.valid_i = 1'b0;
    bus16.op_a_i  = 16'h0;
    lat = 0;
    while (!bus16.valid_o && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_output({tag, "/latency"}, lat, 5);
    check_output({tag, "/result"}, bus16.result_o, exp_res);
    check_output({tag, "/overflow"}, bus16.overflow_o, exp_ovf);
    @(posedge clk);
    #1;
    check_output({tag, "/post_valid"}, bus16.valid_o, 0);
  endtask

  initial begin
    logic [31:0] ra, rb, racc, rres;
    logic        rovf;
    bit          rsgn, rsub, rsat;
    int          seen;

    bus.valid_i = 1'b0;  bus.op_a_i = '0;  bus.op_b_i = '0;  bus.acc_i = '0;
    bus.signed_i = 1'b0; bus.sub_i = 1'b0; bus.sat_i = 1'b0; bus.flush_i = 1'b0;
    bus.ready_i = 1'b1;
    bus16.valid_i = 1'b0;  bus16.op_a_i = '0;  bus16.op_b_i = '0;  bus16.acc_i = '0;
    bus16.signed_i = 1'b0; bus16.sub_i = 1'b0; bus16.sat_i = 1'b0; bus16.flush_i = 1'b0;
    bus16.ready_i = 1'b1;

    #1 rst = 1'b1;
    #11;
    check_output("reset/valid", bus.valid_o, 0);
    check_output("reset/result", bus.result_o, 0);
    check_output("reset/overflow", bus.overflow_o, 0);
    check_output("reset/ready_in_reset", bus.ready_o, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_output("reset/ready", bus.ready_o, 1);

    apply_stimulus(32'd3, 32'd5, 32'd7, 0, 0, 0, 32'd22, 1'b0, 0, "t1_unsigned");
    apply_stimulus(32'hFFFFFFFC, 32'd6, 32'd10, 1, 0, 0, 32'hFFFFFFF2, 1'b0, 0, "t2_add");
    apply_stimulus(32'hFFFFFFFC, 32'd6, 32'd10, 1, 1, 0, 32'h00000022, 1'b0, 0, "t2_sub");
    apply_stimulus(32'h7FFFFFFF, 32'd2, 32'd0, 1, 0, 0, 32'hFFFFFFFE, 1'b1, 0, "t3_wrap");
    apply_stimulus(32'h7FFFFFFF, 32'd2, 32'd0, 1, 0, 1, 32'h7FFFFFFF, 1'b1, 0, "t3_sat");
    apply_stimulus(32'd1, 32'd1, 32'd0, 0, 1, 1, 32'h0, 1'b1, 0, "t3_usat_low");
    apply_stimulus(32'd100, 32'd200, 32'd5, 0, 0, 0, 32'd20005, 1'b0, 5, "t4_stall");

    // Flush part-way through MULT.
    @(negedge clk);
    bus.valid_i = 1'b1; bus.op_a_i = 32'd9; bus.op_b_i = 32'd9; bus.acc_i = 32'd0;
    bus.signed_i = 1'b0; bus.sub_i = 1'b0; bus.sat_i = 1'b0;
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    bus.flush_i = 1'b1;
    #1;
    check_output("t5_flush/ready_during", bus.ready_o, 0);
    @(posedge clk);
    #1;
    bus.flush_i = 1'b0;
    #1;
    check_output("t5_flush/ready_after", bus.ready_o, 1);
    check_output("t5_flush/valid_after", bus.valid_o, 0);
    check_output("t5_flush/result_kept", bus.result_o, 32'd20005);
    seen = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (bus.valid_o) seen++;
    end
    check_output("t5_flush/no_result", seen, 0);

    // Flush in IDLE blocks an accept.
    @(negedge clk);
    bus.flush_i = 1'b1;
    bus.valid_i = 1'b1;
    #1;
    check_output("t5_idle_flush/ready", bus.ready_o, 0);
    @(posedge clk);
    #1;
    bus.flush_i = 1'b0;
    bus.valid_i = 1'b0;
    #1;
    check_output("t5_idle_flush/not_accepted", bus.ready_o, 1);

    apply_stimulus(32'd2, 32'd3, 32'd1, 0, 0, 0, 32'd7, 1'b0, 0, "t5_after_flush");

    // Reset pulse mid-MULT.
    @(negedge clk);
    bus.valid_i = 1'b1; bus.op_a_i = 32'd5; bus.op_b_i = 32'd5; bus.acc_i = 32'd1;
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_output("t5_rst/valid", bus.valid_o, 0);
    check_output("t5_rst/result", bus.result_o, 0);
    check_output("t5_rst/overflow", bus.overflow_o, 0);
    check_output("t5_rst/ready", bus.ready_o, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_output("t5_rst/ready_release", bus.ready_o, 1);

    apply16(16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 16'h0000, 1'b1, "t6_wrap");
    apply16(16'hFFFF, 16'hFFFF, 16'hFFFF, 1, 16'hFFFF, 1'b1, "t6_sat");

    for (int k = 0; k < 24; k++) begin
      case ($urandom_range(0, 3))
        0:       ra = 32'h7FFFFFFF;
        1:       ra = 32'h80000000;
        default: ra = $urandom;
      endcase
      rb   = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
      racc = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
      if ($urandom_range(0, 2) == 0) rb = $urandom_range(0, 7);
      rsgn = 1'($urandom_range(0, 1));
      rsub = 1'($urandom_range(0, 1));
      rsat = 1'($urandom_range(0, 1));
      model(ra, rb, racc, rsgn, rsub, rsat, 32, rres, rovf);
      apply_stimulus(ra, rb, racc, rsgn, rsub, rsat, rres, rovf, $urandom_range(0, 2), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
